cache_write_buffer: RTL and testbench
=====================================

// Module: cache_write_buffer
// PURPOSE
//  Posted-write FIFO between the data cache and main RAM. Accepts cache write-through stores,
//  retires them to RAM one at a time over a req/ack handshake, and lets the cache fill path
//  read the newest pending data for a word, so a line refill never returns stale RAM contents.
// PARAMETERS
//  DEPTH  4  entries, power of 2, >=2; pointers are log2(DEPTH) bits, count is log2(DEPTH)+1 bits
//  AW     32 byte-address width; entries store and compare the word address addr[AW-1:2]
//  DW     32 data width (one word per entry)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  wr_valid   in   1      cache presents a store
//  wr_ready   out  1      buffer accepts; push = wr_valid & wr_ready
//  wr_addr    in   AW     store byte address; bits [1:0] ignored
//  wr_data    in   DW     store data
//  lk_addr    in   AW     fill-path lookup address
//  lk_hit     out  1      combinational: some valid entry has word address == lk_addr[AW-1:2]
//  lk_data    out  DW     data of the youngest matching entry; 0 when lk_hit=0
//  mem_req    out  1      write request to RAM
//  mem_addr   out  AW     head entry address, {word,2'b00}
//  mem_data   out  DW     head entry data
//  mem_ack    in   1      RAM has taken the write (single-cycle pulse)
//  count      out  log2(DEPTH)+1  occupied entries
//  empty      out  1      count==0
//  full       out  1      count==DEPTH
// BEHAVIOUR
//  Reset: all entries invalid; head/tail/count=0; FSM=IDLE; mem_req=0; wr_ready=1; empty=1;
//   full=0; mem_addr/mem_data=0. Reset mid-drain drops mem_req asynchronously; the in-flight
//   write is discarded and no ack is awaited.
//  wr_ready = !full. It is never asserted on full, even when a pop happens in the same cycle.
//  Push: entry[tail]<={wr_addr[AW-1:2],wr_data}; tail wraps DEPTH-1 -> 0.
//  Drain FSM:
//   IDLE: mem_req=0. If !empty, go to REQ next cycle.
//   REQ:  mem_req=1; mem_addr/mem_data are registered from head, loaded on entry to REQ and
//         held stable until ack. On mem_ack: pop head (head wraps), go to IDLE.
//  Back-to-back writes therefore have one idle cycle between them. Push-to-first-mem_req
//   latency is 2 cycles from an empty buffer.
//  mem_ack outside REQ is ignored.
//  Simultaneous push and pop: count unchanged; both pointers advance.
//  Lookup: compare against every valid entry, including the head while in flight. Youngest
//   (closest to tail) wins. A store pushed this cycle is not visible until the next cycle.
//  count/empty/full are registered and update on the edge after push/pop.
// CONFIGURATION
//  WB_COALESCE_EN defined: a push whose word address equals the youngest valid entry, and that
//   entry is not the head in REQ, overwrites that entry's data in place. No allocation; count
//   unchanged. This is allowed when full (wr_ready=1 if full && coalescible).
//  Undefined: every push allocates a new entry; wr_ready = !full strictly.
// TESTING
//  T1 reset mid-REQ: push 0x100/0xA5A5A5A5, wait for mem_req=1, pulse rst_n=0 -> mem_req=0
//     immediately, count=0, empty=1, lk_hit=0 for 0x100.
//  T2 fill/drain: hold mem_ack=0, push 0x10,0x14,0x18,0x1C -> full=1, wr_ready=0. Then ack
//     each request -> RAM sees 0x10,0x14,0x18,0x1C in order, idle gap of 1 cycle, empty=1.
//  T3 forwarding: push 0x40/1 then 0x40/2 (no coalesce) -> lk_addr=0x42 gives lk_hit=1,
//     lk_data=2. After both drain -> lk_hit=0.
//  T4 simultaneous: count=2, mem_ack and push in the same cycle -> count stays 2, tail and
//     head both advance, order preserved.
//  T5 wrap: push/drain 9 entries with DEPTH=4 -> pointers wrap twice, data intact.
//  T6 WB_COALESCE_EN: full buffer, youngest 0x80/7, push 0x80/9 -> accepted, count=4,
//     drained value for 0x80 is 9. Without the macro -> wr_ready=0.

Source files
------------

// File: rtl/cache_write_buffer.sv
// Posted-write FIFO between data cache and RAM with youngest-match store forwarding for the fill path.
// Optional in-place store coalescing into the youngest entry is enabled by defining WB_COALESCE_EN.
module cache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DW-1:0]              wr_data,
    input  logic [AW-1:0]              lk_addr,
    output logic                       lk_hit,
    output logic [DW-1:0]              lk_data,
    output logic                       mem_req,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_data,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - 2;

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state, state_nx;
    logic [WW-1:0]       ent_addr [DEPTH];
    logic [DW-1:0]       ent_data [DEPTH];
    logic [DEPTH-1:0]    ent_vld;
    logic [PW-1:0]       head, tail, yng, lk_idx;
    logic                coal_ok, hd_busy, push, push_new, push_coal, pop;
    logic                unused_lsbs;

    assign unused_lsbs = ^{wr_addr[1:0], lk_addr[1:0]};

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign yng      = tail - 1'b1;
    // The head is committed to RAM once the FSM leaves IDLE with work, so it must not be rewritten.
    assign hd_busy  = (state == REQ) || !empty;

`ifdef WB_COALESCE_EN
    assign coal_ok  = !empty && ent_vld[yng] && (ent_addr[yng] == wr_addr[AW-1:2]) &&
                      !((yng == head) && hd_busy);
`else
    assign coal_ok  = 1'b0;
`endif

    assign wr_ready  = !full || coal_ok;
    assign push      = wr_valid && wr_ready;
    assign push_coal = push && coal_ok;
    assign push_new  = push && !coal_ok;
    assign pop       = (state == REQ) && mem_ack;

    // Drain FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Drain FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = REQ;
            REQ:     if (mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        mem_req = (state == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_vld  <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (push_new) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (push_new && !pop)      count <= count + 1'b1;
            else if (pop && !push_new) count <= count - 1'b1;
            if (state == IDLE && !empty) begin
                mem_addr <= {ent_addr[head], 2'b00};
                mem_data <= ent_data[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_new) begin
            ent_addr[tail] <= wr_addr[AW-1:2];
            ent_data[tail] <= wr_data;
        end else if (push_coal) begin
            ent_data[yng] <= wr_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head + i[PW-1:0];
            if (ent_vld[lk_idx] && (ent_addr[lk_idx] == lk_addr[AW-1:2])) begin
                lk_hit  = 1'b1;
                lk_data = ent_data[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer: reset, fill/drain ordering, forwarding, simultaneous push/pop, wrap, coalescing.
module tb_cache_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] lk_addr = '0;
    logic          lk_hit;
    logic [DW-1:0] lk_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack = 1'b0;
    logic [2:0]    count;
    logic          empty, full;

    int n_checks = 0;
    int n_errors = 0;

    cache_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        #1;
        chk("push_ready", wr_ready, 1'b1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    // Waits for a bounded number of cycles for mem_req, checks the presented write and acks it.
    task automatic drain(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", mem_req, 1'b1);
        chk("mem_addr", mem_addr, a);
        chk("mem_data", mem_data, d);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_gap", mem_req, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", wr_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mdata", mem_data, 0);

        // T1: reset while a write is in flight
        push(32'h100, 32'hA5A5_A5A5);
        chk("t1_lat_idle", mem_req, 1'b0);
        step();
        chk("t1_lat_req", mem_req, 1'b1);
        lk_addr = 32'h100;
        #1;
        chk("t1_hit_pre", lk_hit, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t1_req_drop", mem_req, 1'b0);
        chk("t1_count", count, 0);
        chk("t1_empty", empty, 1'b1);
        chk("t1_hit", lk_hit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // T2: fill then drain in order
        push(32'h10, 32'h1);
        push(32'h14, 32'h2);
        push(32'h18, 32'h3);
        push(32'h1C, 32'h4);
        chk("t2_full", full, 1'b1);
        chk("t2_ready", wr_ready, 1'b0);
        chk("t2_count", count, 4);
        drain(32'h10, 32'h1);
        drain(32'h14, 32'h2);
        drain(32'h18, 32'h3);
        drain(32'h1C, 32'h4);
        chk("t2_empty", empty, 1'b1);

        // T3: forwarding picks the youngest match
        push(32'h40, 32'h1);
        push(32'h40, 32'h2);
        lk_addr = 32'h42;
        #1;
        chk("t3_hit", lk_hit, 1'b1);
        chk("t3_data", lk_data, 32'h2);
        chk("t3_count", count, 2);
        lk_addr = 32'h44;
        #1;
        chk("t3_miss", lk_hit, 1'b0);
        chk("t3_miss_data", lk_data, 0);
        lk_addr = 32'h40;
        drain(32'h40, 32'h1);
        drain(32'h40, 32'h2);
        #1;
        chk("t3_gone", lk_hit, 1'b0);

        // T4: push and pop on the same edge
        push(32'h200, 32'h11);
        push(32'h204, 32'h22);
        while (!mem_req) step();
        chk("t4_head", mem_addr, 32'h200);
        mem_ack  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 32'h208;
        wr_data  = 32'h33;
        step();
        mem_ack  = 1'b0;
        wr_valid = 1'b0;
        chk("t4_count", count, 2);
        drain(32'h204, 32'h22);
        drain(32'h208, 32'h33);
        chk("t4_empty", empty, 1'b1);

        // T5: nine entries through the ring
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++)
                push(32'h1000 + 32'((r*3 + k) * 4), 32'hC0DE_0000 + 32'(r*3 + k));
            for (int k = 0; k < 3; k++)
                drain(32'h1000 + 32'((r*3 + k) * 4), 32'hC0DE_0000 + 32'(r*3 + k));
        end
        chk("t5_empty", empty, 1'b1);

        // T6: store to the youngest address on a full buffer
        push(32'h300, 32'h1);
        push(32'h304, 32'h2);
        push(32'h308, 32'h3);
        push(32'h80, 32'h7);
        chk("t6_full", full, 1'b1);
        wr_valid = 1'b1;
        wr_addr  = 32'h80;
        wr_data  = 32'h9;
        #1;
`ifdef WB_COALESCE_EN
        chk("t6_ready", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
        chk("t6_count", count, 4);
        drain(32'h300, 32'h1);
        drain(32'h304, 32'h2);
        drain(32'h308, 32'h3);
        drain(32'h80, 32'h9);
`else
        chk("t6_ready", wr_ready, 1'b0);
        step();
        wr_valid = 1'b0;
        chk("t6_count", count, 4);
        drain(32'h300, 32'h1);
        drain(32'h304, 32'h2);
        drain(32'h308, 32'h3);
        drain(32'h80, 32'h7);
`endif
        chk("t6_empty", empty, 1'b1);

        // Ack outside REQ is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stray_ack", count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end
endmodule
